// File: rtl/d_branch_pkg.sv
// Shared definitions for the D-stage branch controller: op encodings,
// FSM state type, PC increment and the branch target function.
package d_branch_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_J    = 3'd3;
    localparam logic [2:0] BR_JAL  = 3'd4;
    localparam logic [2:0] BR_JR   = 3'd5;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Next-PC target for a taken branch; all arithmetic wraps mod 2^32.
    function automatic logic [31:0] branch_target(
        input logic [2:0]  op,
        input logic [31:0] pc,
        input logic [15:0] imm16,
        input logic [25:0] index26,
        input logic [31:0] rs_data
    );
        logic [31:0] pc4;
        logic signed [31:0] offs;
        pc4  = pc + PC_INC;
        offs = $signed({{14{imm16[15]}}, imm16, 2'b00});
        case (op)
            BR_J, BR_JAL: branch_target = {pc4[31:28], index26, 2'b00};
            BR_JR:        branch_target = rs_data;
            default:      branch_target = pc4 + $unsigned(offs);
        endcase
    endfunction

endpackage

// File: rtl/d_branch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already at the maximum value.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register; clear has priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/d_branch_ctrl.sv
// D-stage branch controller: waits for forwarded operands, drives the
// comparator enables, schedules a registered next-PC redirect, and keeps
// a stall watchdog plus taken/stall statistics.
module d_branch_ctrl
    import d_branch_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       br_op,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             D_kill,
    input  logic [31:0]      D_pc,
    input  logic [15:0]      imm16,
    input  logic [25:0]      index26,
    input  logic [31:0]      rs_data,
    input  logic             cmp_judge,
    output logic             cmp_beq,
    output logic             cmp_bne,
    output logic             stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             timeout,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

    state_e          state_q, state_d;
    logic [WC_W-1:0] wait_q, wait_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;
    logic            timeout_q, timeout_d;

    logic is_cond, is_br, ready, resolve, taken, redir_set;

    // Decode the op and check its operand need-set (6/7 count as none).
    always_comb begin
        is_cond = (br_op == BR_BEQ) || (br_op == BR_BNE);
        is_br   = is_cond || (br_op == BR_J) || (br_op == BR_JAL) || (br_op == BR_JR);
        ready   = (!(is_cond || (br_op == BR_JR)) || rs_ready) && (!is_cond || rt_ready);
        taken   = is_cond ? cmp_judge : is_br;
    end

    // Next-state, combinational outputs and registered-output updates.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stall     = 1'b0;
        cmp_beq   = 1'b0;
        cmp_bne   = 1'b0;
        resolve   = 1'b0;
        redir_set = 1'b0;
        timeout_d = timeout_q;
        if (reset || D_kill) begin
            state_d = ST_IDLE;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_br) begin
                        if (ready) begin
                            resolve = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = ST_WAIT;
                            wait_d  = WC_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (ready) begin
                        resolve = 1'b1;
                        state_d = ST_IDLE;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LIM) begin
                        state_d   = ST_IDLE;
                        wait_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        stall  = 1'b1;
                        wait_d = wait_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end
            endcase
            if (resolve) begin
                cmp_beq   = (br_op == BR_BEQ);
                cmp_bne   = (br_op == BR_BNE);
                redir_set = is_br && taken;
            end
        end
        redirect_valid_d = redir_set;
        redirect_pc_d    = redir_set ? branch_target(br_op, D_pc, imm16, index26, rs_data)
                                     : redirect_pc_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            wait_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_q           <= wait_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            timeout_q        <= timeout_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign timeout        = timeout_q;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (redir_set),
        .count (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Directed bench for d_branch_ctrl: single-cycle resolve table plus
// hand-written wait/timeout/kill/reset/saturation sequences.
module tb_d_branch_ctrl;
    import d_branch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  br_op;
    logic        rs_ready, rt_ready, D_kill, cmp_judge;
    logic [31:0] D_pc, rs_data;
    logic [15:0] imm16;
    logic [25:0] index26;

    logic        cmp_beq, cmp_bne, stall, redirect_valid, timeout;
    logic [31:0] redirect_pc;
    logic [15:0] taken_cnt, stall_cnt;

    logic        cmp_beq2, cmp_bne2, stall2, redirect_valid2, timeout2;
    logic [31:0] redirect_pc2;
    logic [1:0]  taken_cnt2, stall_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    d_branch_ctrl #(.CNT_W(16), .WAIT_MAX(3)) dut (
        .clk(clk), .reset(reset), .br_op(br_op), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .D_kill(D_kill), .D_pc(D_pc), .imm16(imm16), .index26(index26), .rs_data(rs_data),
        .cmp_judge(cmp_judge), .cmp_beq(cmp_beq), .cmp_bne(cmp_bne), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .timeout(timeout),
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    d_branch_ctrl #(.CNT_W(2), .WAIT_MAX(3)) dut2 (
        .clk(clk), .reset(reset), .br_op(br_op), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .D_kill(D_kill), .D_pc(D_pc), .imm16(imm16), .index26(index26), .rs_data(rs_data),
        .cmp_judge(cmp_judge), .cmp_beq(cmp_beq2), .cmp_bne(cmp_bne2), .stall(stall2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .timeout(timeout2),
        .taken_cnt(taken_cnt2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic [2:0]  op;
        logic        rs_rdy;
        logic        rt_rdy;
        logic        kill;
        logic        judge;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rsd;
        logic        e_stall;
        logic        e_beq;
        logic        e_bne;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        br_op = BR_NONE; rs_ready = 1'b0; rt_ready = 1'b0; D_kill = 1'b0;
        cmp_judge = 1'b0; D_pc = '0; imm16 = '0; index26 = '0; rs_data = '0;
    endtask

    initial begin
        //           op       rs rt kl jd pc            imm       idx          rsd           st bq bn rv rpc
        tbl[0]  = '{BR_BEQ,  1, 1, 0, 1, 32'h0000_3000, 16'h0004, 26'h0,       32'h0,        0, 1, 0, 1, 32'h0000_3014};
        tbl[1]  = '{BR_BEQ,  1, 1, 0, 0, 32'h0000_4000, 16'h0008, 26'h0,       32'h0,        0, 1, 0, 0, 32'h0000_3014};
        tbl[2]  = '{BR_BNE,  1, 1, 0, 1, 32'h0000_1000, 16'hFFFE, 26'h0,       32'h0,        0, 0, 1, 1, 32'h0000_0FFC};
        tbl[3]  = '{BR_J,    0, 0, 0, 0, 32'hFFFF_FFFC, 16'h0,    26'h0000001, 32'h0,        0, 0, 0, 1, 32'h0000_0004};
        tbl[4]  = '{BR_JAL,  0, 0, 0, 0, 32'h1234_5678, 16'h0,    26'h3FFFFFF, 32'h0,        0, 0, 0, 1, 32'h1FFF_FFFC};
        tbl[5]  = '{BR_JR,   1, 0, 0, 0, 32'h0000_2000, 16'h0,    26'h0,       32'hDEAD_BEEF, 0, 0, 0, 1, 32'hDEAD_BEEF};
        tbl[6]  = '{3'd6,    0, 0, 0, 1, 32'h0000_5000, 16'h0010, 26'h0000123, 32'h0,        0, 0, 0, 0, 32'hDEAD_BEEF};
        tbl[7]  = '{BR_NONE, 0, 0, 0, 1, 32'h0000_6000, 16'h0010, 26'h0,       32'h0,        0, 0, 0, 0, 32'hDEAD_BEEF};
        tbl[8]  = '{BR_BNE,  1, 1, 0, 0, 32'h0000_7000, 16'h0020, 26'h0,       32'h0,        0, 0, 1, 0, 32'hDEAD_BEEF};
        tbl[9]  = '{BR_BEQ,  1, 1, 1, 1, 32'h0000_8000, 16'h0020, 26'h0,       32'h0,        0, 0, 0, 0, 32'hDEAD_BEEF};
        tbl[10] = '{BR_BEQ,  0, 0, 1, 1, 32'h0000_9000, 16'h0020, 26'h0,       32'h0,        0, 0, 0, 0, 32'hDEAD_BEEF};

        // Reset with a ready beq on the inputs: combinational outputs stay low.
        idle_in();
        reset = 1'b1; br_op = BR_BEQ; rs_ready = 1'b1; rt_ready = 1'b1; cmp_judge = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_cmp_beq", cmp_beq, 0);
        tick(); tick();
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_taken", taken_cnt, 0);
        chk("rst_stallcnt", stall_cnt, 0);
        reset = 1'b0;
        idle_in();
        tick();

        // Single-cycle resolves from IDLE.
        for (int i = 0; i < 11; i++) begin
            br_op = tbl[i].op; rs_ready = tbl[i].rs_rdy; rt_ready = tbl[i].rt_rdy;
            D_kill = tbl[i].kill; cmp_judge = tbl[i].judge; D_pc = tbl[i].pc;
            imm16 = tbl[i].imm; index26 = tbl[i].idx; rs_data = tbl[i].rsd;
            #1;
            chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
            chk($sformatf("v%0d_cmp_beq", i), cmp_beq, tbl[i].e_beq);
            chk($sformatf("v%0d_cmp_bne", i), cmp_bne, tbl[i].e_bne);
            tick();
            chk($sformatf("v%0d_rv", i), redirect_valid, tbl[i].e_rv);
            chk($sformatf("v%0d_rpc", i), redirect_pc, tbl[i].e_rpc);
        end
        chk("tbl_taken", taken_cnt, 5);
        chk("tbl_stallcnt", stall_cnt, 0);
        chk("sat_taken_w2", taken_cnt2, 3);
        idle_in();
        tick();

        // bne waiting on rt for two cycles, negative offset.
        br_op = BR_BNE; D_pc = 32'h0000_3010; imm16 = 16'hFFFF; rs_ready = 1'b1; rt_ready = 1'b0; cmp_judge = 1'b1;
        #1;
        chk("bne_w1_stall", stall, 1);
        tick();
        chk("bne_w2_stall", stall, 1);
        chk("bne_w2_cmp", cmp_bne, 0);
        tick();
        rt_ready = 1'b1;
        #1;
        chk("bne_res_stall", stall, 0);
        chk("bne_res_cmp", cmp_bne, 1);
        tick();
        chk("bne_rv", redirect_valid, 1);
        chk("bne_rpc", redirect_pc, 32'h0000_3010);
        chk("bne_stallcnt", stall_cnt, 2);
        chk("bne_taken", taken_cnt, 6);
        idle_in();
        tick();
        chk("bne_rv_one", redirect_valid, 0);

        // jr never gets rs: timeout on the fourth cycle.
        br_op = BR_JR; rs_data = 32'h0000_ABC0;
        #1;
        chk("jr_c1_stall", stall, 1);
        tick();
        chk("jr_c2_stall", stall, 1);
        tick();
        chk("jr_c3_stall", stall, 1);
        tick();
        chk("jr_c4_stall", stall, 0);
        chk("jr_c4_to_pre", timeout, 0);
        tick();
        idle_in();
        #1;
        chk("jr_timeout", timeout, 1);
        chk("jr_rv", redirect_valid, 0);
        chk("jr_rpc", redirect_pc, 32'h0000_3010);
        chk("jr_stallcnt", stall_cnt, 5);
        chk("sat_stall_w2", stall_cnt2, 3);
        tick();

        // beq killed in its second wait cycle, then re-entered fresh.
        br_op = BR_BEQ; cmp_judge = 1'b1; D_pc = 32'h0000_0100; imm16 = 16'h0001;
        #1;
        chk("kill_c1_stall", stall, 1);
        tick();
        chk("kill_w1_stall", stall, 1);
        tick();
        D_kill = 1'b1;
        #1;
        chk("kill_stall", stall, 0);
        chk("kill_cmp", cmp_beq, 0);
        tick();
        chk("kill_rv", redirect_valid, 0);
        D_kill = 1'b0;
        #1;
        chk("fresh_c1_stall", stall, 1);
        tick();
        chk("fresh_c2_stall", stall, 1);
        tick();
        chk("fresh_c3_stall", stall, 1);
        tick();
        chk("fresh_c4_stall", stall, 0);
        tick();
        chk("fresh_rv", redirect_valid, 0);
        chk("fresh_stallcnt", stall_cnt, 10);
        chk("timeout_sticky", timeout, 1);
        idle_in();
        tick();

        // Reset while waiting abandons the branch.
        br_op = BR_BNE; D_pc = 32'h0000_0200; imm16 = 16'h0003;
        #1;
        chk("rw_stall", stall, 1);
        tick();
        reset = 1'b1; rs_ready = 1'b1; rt_ready = 1'b1; cmp_judge = 1'b1;
        #1;
        chk("rw_rst_stall", stall, 0);
        chk("rw_rst_cmp", cmp_bne, 0);
        tick();
        chk("rw_rv", redirect_valid, 0);
        chk("rw_rpc", redirect_pc, 0);
        chk("rw_timeout", timeout, 0);
        chk("rw_taken", taken_cnt, 0);
        chk("rw_stallcnt", stall_cnt, 0);
        chk("rw_taken_w2", taken_cnt2, 0);
        reset = 1'b0;
        idle_in();
        tick();
        chk("rw_after_rv", redirect_valid, 0);

        // Back-to-back: beq resolves, jal follows in the next cycle.
        br_op = BR_BEQ; rs_ready = 1'b1; rt_ready = 1'b1; cmp_judge = 1'b1;
        D_pc = 32'h0000_3000; imm16 = 16'h0004;
        #1;
        chk("b2b_cmp", cmp_beq, 1);
        tick();
        chk("b2b_rv1", redirect_valid, 1);
        chk("b2b_rpc1", redirect_pc, 32'h0000_3014);
        br_op = BR_JAL; D_pc = 32'h0040_0000; index26 = 26'h0000010; rs_ready = 1'b0; rt_ready = 1'b0;
        #1;
        chk("b2b_stall", stall, 0);
        chk("b2b_rv1_hold", redirect_valid, 1);
        tick();
        chk("b2b_rv2", redirect_valid, 1);
        chk("b2b_rpc2", redirect_pc, 32'h0000_0040);
        chk("b2b_taken", taken_cnt, 2);
        idle_in();
        tick();
        chk("b2b_rv_end", redirect_valid, 0);
        chk("b2b_rpc_hold", redirect_pc, 32'h0000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
